fixed_point_divider: RTL and testbench

Sequential unsigned fixed-point divider, the inverse of the fixed-point multiply path; a companion execution unit beside the fixed-point unit.
- Computes operand_1 / operand_2 on Q(WIDTH-FBITS).FBITS operands using radix-2 restoring division, one quotient bit per clock.
- Uses a start/busy/ready handshake; the CPU stalls on ~ready.

---
 rtl/fixed_point_divider.sv | 233 +++++++++++++++++++++++
 tb/tb_fixed_point_divider.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential fixed-point divider, Q(WIDTH-FBITS).FBITS.
// Radix-2 restoring division producing one quotient bit per clock, with a
// start/busy/ready handshake. Unsigned by default; defining the macro
// FIXED_DIV_SIGNED_EN switches to two's-complement operands, which costs one
// extra sign fix-up cycle.
module fixed_point_divider #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  // The dividend is pre-scaled by 2^FBITS, so it spans WIDTH+FBITS bits.
  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
`ifdef FIXED_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       dvd_q, dvd_d;       // shifting dividend
  logic [WIDTH-1:0]   dvs_q, dvs_d;       // latched divisor (magnitude)
  logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder, always < divisor
  logic [N-1:0]       quo_q, quo_d;       // quotient being assembled
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
`ifdef FIXED_DIV_SIGNED_EN
  logic               neg_q, neg_d;       // quotient must be negated at the end
  logic               fix_q, fix_d;       // in the sign fix-up cycle
`endif

  // Operand magnitudes fed into the unsigned datapath.
  logic [WIDTH-1:0]   mag_1;
  logic [WIDTH-1:0]   mag_2;

  // One restoring step: the remainder grows to WIDTH+1 bits before compare.
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [N-1:0]       quo_step;

`ifdef FIXED_DIV_SIGNED_EN
  // The most negative value has magnitude 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits, so plain negation is exact.
  assign mag_1 = operand_1[WIDTH-1] ? -operand_1 : operand_1;
  assign mag_2 = operand_2[WIDTH-1] ? -operand_2 : operand_2;
`else
  assign mag_1 = operand_1;
  assign mag_2 = operand_2;
`endif

  assign rem_shift = {rem_q, dvd_q[N-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  // True difference is below the divisor, so modular WIDTH-bit math is exact.
  assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;
  assign quo_step  = {quo_q[N-2:0], rem_ge};

`ifdef FIXED_DIV_SIGNED_EN
  logic sat_hi;
  logic mag_top;
  logic mag_low;
  assign sat_hi  = |quo_q[N-1:WIDTH];
  assign mag_top = quo_q[WIDTH-1];
  assign mag_low = |quo_q[WIDTH-2:0];
`else
  // Bits that land at or above WIDTH once the last quotient bit shifts in.
  // Bit N-1 is always zero by then; it is kept so the whole register is checked.
  logic quo_hi;
  assign quo_hi = |quo_q[N-1:WIDTH-1];
`endif

  // Next-state and datapath control for the IDLE/CALC sequencer.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
`ifdef FIXED_DIV_SIGNED_EN
    neg_d    = neg_q;
    fix_d    = fix_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          if (operand_2 == '0) begin
            // Zero divisor resolves immediately without entering CALC.
`ifdef FIXED_DIV_SIGNED_EN
            result_d = operand_1[WIDTH-1] ? MIN_NEG : MAX_POS;
`else
            result_d = ALL_ONES;
`endif
            dbz_d    = 1'b1;
            ready_d  = 1'b1;
          end else begin
            dvd_d   = {mag_1, {FBITS{1'b0}}};
            dvs_d   = mag_2;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CNT_LAST;
            busy_d  = 1'b1;
            state_d = CALC;
`ifdef FIXED_DIV_SIGNED_EN
            neg_d   = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
            fix_d   = 1'b0;
`endif
          end
        end
      end

      CALC: begin
`ifdef FIXED_DIV_SIGNED_EN
        if (fix_q) begin
          // Saturate to the signed range, then apply the result sign.
          busy_d  = 1'b0;
          ready_d = 1'b1;
          fix_d   = 1'b0;
          state_d = IDLE;
          if (neg_q) begin
            ovf_d    = sat_hi | (mag_top & mag_low);
            result_d = (sat_hi | (mag_top & mag_low)) ? MIN_NEG : -quo_q[WIDTH-1:0];
          end else begin
            ovf_d    = sat_hi | mag_top;
            result_d = (sat_hi | mag_top) ? MAX_POS : quo_q[WIDTH-1:0];
          end
        end else begin
          rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
          quo_d = quo_step;
          if (cnt_q == '0) begin
            fix_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
`else
        rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
        dvd_d = {dvd_q[N-2:0], 1'b0};
        quo_d = quo_step;
        if (cnt_q == '0) begin
          // Last bit: anything above WIDTH bits saturates.
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          ovf_d    = quo_hi;
          result_d = quo_hi ? ALL_ONES : quo_step[WIDTH-1:0];
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any division in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef FIXED_DIV_SIGNED_EN
      neg_q    <= 1'b0;
      fix_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
`ifdef FIXED_DIV_SIGNED_EN
      neg_q    <= neg_d;
      fix_q    <= fix_d;
`endif
    end
  end

  assign result      = result_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: scoreboard bench for fixed_point_divider.
// Expected results come from a native 64-bit division model and are queued
// when a start is driven, then popped when ready is observed.
module tb_fixed_point_divider;

  localparam int WIDTH = 32;
  localparam int FBITS = 10;
  localparam int N     = WIDTH + FBITS;
`ifdef FIXED_DIV_SIGNED_EN
  localparam int LAT   = N + 1;
`else
  localparam int LAT   = N;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  operand_1 = '0;
  logic [WIDTH-1:0]  operand_2 = '0;
  logic [WIDTH-1:0]  result;
  logic              ready;
  logic              busy;
  logic              div_by_zero;
  logic              overflow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];

  fixed_point_divider #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .result      (result),
    .ready       (ready),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: exact integer division of the pre-scaled dividend.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] q;
    logic [63:0] m1;
    logic [63:0] m2;
    logic [31:0] t;
    e = '0;
`ifdef FIXED_DIV_SIGNED_EN
    m1 = a[31] ? {32'd0, -a} : {32'd0, a};
    m2 = b[31] ? {32'd0, -b} : {32'd0, b};
    if (b == 32'd0) begin
      e.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dbz = 1'b1;
      e.lat = 8'd0;
    end else begin
      q = (m1 << FBITS) / m2;
      e.lat = 8'(LAT);
      if (a[31] ^ b[31]) begin
        if (q > 64'h8000_0000) begin
          e.res = 32'h8000_0000;
          e.ovf = 1'b1;
        end else begin
          t = q[31:0];
          e.res = -t;
        end
      end else begin
        if (q > 64'h7FFF_FFFF) begin
          e.res = 32'h7FFF_FFFF;
          e.ovf = 1'b1;
        end else begin
          e.res = q[31:0];
        end
      end
    end
`else
    m1 = {32'd0, a};
    m2 = {32'd0, b};
    if (b == 32'd0) begin
      e.res = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
      e.lat = 8'd0;
    end else begin
      q = (m1 << FBITS) / m2;
      e.lat = 8'(LAT);
      if ((q >> 32) != 64'd0) begin
        e.res = 32'hFFFF_FFFF;
        e.ovf = 1'b1;
      end else begin
        e.res = q[31:0];
      end
    end
`endif
    return e;
  endfunction

  // Drive one start, scramble the operand pins afterwards, and wait for ready.
  // Optionally pulses a second start inside CALC (inject_at > 0).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                         output logic [31:0] res, output logic dbz, output logic ovf,
                         output int lat, output int busy_bad);
    @(negedge clk);
    operand_1 = a;
    operand_2 = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    operand_1 = $urandom;
    operand_2 = $urandom;
    lat = 0;
    busy_bad = 0;
    while (!ready && lat < 200) begin
      if (!busy) busy_bad++;
      if (inject_at > 0 && lat == inject_at) begin
        start = 1'b1;
        operand_1 = 32'h0000_0C00;
        operand_2 = 32'h0000_0800;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (ready && busy) busy_bad++;
    res = result;
    dbz = div_by_zero;
    ovf = overflow;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({result, ready, busy, div_by_zero, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%h/%b%b%b%b expected all zero", result, ready, busy, div_by_zero, overflow);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r; logic d, o; int lat, bb; exp_t e;
    run_div(a, b, 0, r, d, o, lat, bb);
    e = exp_q.pop_front();
    $display("%s: %h / %h -> %h dbz=%b ovf=%b lat=%0d", tag, a, b, r, d, o, lat);
    n_cmp++;
    if ({r, d, o} !== {e.res, e.dbz, e.ovf}) begin
      n_bad++;
      $display("FAIL %s_value got=%h/%b%b expected %h/%b%b", tag, r, d, o, e.res, e.dbz, e.ovf);
    end
    n_cmp++;
    if (lat !== int'(e.lat)) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d expected %0d", tag, lat, e.lat);
    end
    n_cmp++;
    if (bb !== 0) begin
      n_bad++;
      $display("FAIL %s_busy got=%0d bad busy samples expected 0", tag, bb);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; logic d, o; int lat, bb; exp_t e;
    run_div(32'h0000_0400, 32'h0000_0000, 0, r, d, o, lat, bb);
    e = exp_q.pop_front();
    $display("div_zero: -> %h dbz=%b busy=%b lat=%0d", r, d, busy, lat);
    n_cmp++;
    if ({r, d, o} !== {e.res, e.dbz, e.ovf}) begin
      n_bad++;
      $display("FAIL div_zero_value got=%h/%b%b expected %h/%b%b", r, d, o, e.res, e.dbz, e.ovf);
    end
    n_cmp++;
    if ({lat, busy} !== {32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL div_zero_timing got lat=%0d busy=%b expected lat=0 busy=0", lat, busy);
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] r; logic d, o; int lat, bb; exp_t e;
    run_div(32'hFFFF_FFFF, 32'h0000_0001, 10, r, d, o, lat, bb);
    e = exp_q.pop_front();
    $display("ignored_start: -> %h ovf=%b lat=%0d", r, o, lat);
    n_cmp++;
    if ({r, d, o} !== {e.res, e.dbz, e.ovf}) begin
      n_bad++;
      $display("FAIL ignored_start_value got=%h/%b%b expected %h/%b%b", r, d, o, e.res, e.dbz, e.ovf);
    end
    n_cmp++;
    if (lat !== int'(e.lat)) begin
      n_bad++;
      $display("FAIL ignored_start_latency got=%0d expected %0d", lat, e.lat);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({result, ready, busy} !== {e.res, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ignored_start_hold got=%h/%b%b expected %h/10", result, ready, busy, e.res);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    operand_1 = 32'h0000_0C00;
    operand_2 = 32'h0000_0800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("reset_abort: result=%h ready=%b busy=%b", result, ready, busy);
    n_cmp++;
    if ({result, ready, busy, div_by_zero, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_abort_clear got=%h/%b%b%b%b expected all zero", result, ready, busy, div_by_zero, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if ({ready, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_abort_no_ready got=%b%b expected 00", ready, busy);
    end
    test_basic(32'h0000_0800, 32'h0000_0400, "after_reset");
  endtask

  task automatic test_back_to_back();
    int cnt; exp_t e;
    @(negedge clk);
    operand_1 = 32'h0000_0400;
    operand_2 = 32'h0000_0C00;
    start = 1'b1;
    exp_q.push_back(model(32'h0000_0400, 32'h0000_0C00));
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!ready && cnt < 200) begin
      if (cnt == LAT - 1) begin
        start = 1'b1;
        operand_1 = 32'h0000_0C00;
        operand_2 = 32'h0000_0800;
      end
      @(negedge clk);
      cnt++;
    end
    e = exp_q.pop_front();
    exp_q.push_back(model(32'h0000_0C00, 32'h0000_0800));
    $display("back_to_back first: -> %h lat=%0d", result, cnt);
    n_cmp++;
    if ({result, cnt} !== {e.res, 32'(e.lat)}) begin
      n_bad++;
      $display("FAIL b2b_first got=%h lat=%0d expected %h lat=%0d", result, cnt, e.res, e.lat);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_accept got ready/busy=%b%b expected 01", ready, busy);
    end
    cnt = 0;
    while (!ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    e = exp_q.pop_front();
    $display("back_to_back second: -> %h lat=%0d", result, cnt);
    n_cmp++;
    if ({result, cnt} !== {e.res, 32'(e.lat)}) begin
      n_bad++;
      $display("FAIL b2b_second got=%h lat=%0d expected %h lat=%0d", result, cnt, e.res, e.lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r; logic d, o; int lat, bb; exp_t e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 4096)) : $urandom;
      run_div(a, b, 0, r, d, o, lat, bb);
      e = exp_q.pop_front();
      $display("random%0d: %h / %h -> %h dbz=%b ovf=%b lat=%0d", i, a, b, r, d, o, lat);
      n_cmp++;
      if ({r, d, o, lat} !== {e.res, e.dbz, e.ovf, 32'(e.lat)}) begin
        n_bad++;
        $display("FAIL random%0d got=%h/%b%b lat=%0d expected %h/%b%b lat=%0d", i, r, d, o, lat, e.res, e.dbz, e.ovf, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(32'h0000_0C00, 32'h0000_0800, "three_halves");
    test_basic(32'h0000_0400, 32'h0000_0C00, "one_third");
    test_div_zero();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
`ifdef FIXED_DIV_SIGNED_EN
    test_basic(32'hFFFF_F400, 32'h0000_0800, "signed_neg");
    test_basic(32'h8000_0000, 32'h0000_0001, "signed_ovf");
    test_basic(32'h8000_0000, 32'h0000_0000, "signed_dbz");
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
